// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl -- load/store unit to CPU data bus bridge.
//
// Takes one-cycle lsu_cmd requests from the memory stage and checks their
// alignment. It runs a single word-addressed bus transaction with byte
// enables and replicated store data, and right-justifies load data. The core
// is stalled (lsu_busy) from the command cycle until the transaction ends.
//
// Ports
//   clk, nrst         clock, async active-low reset
//   lsu_addr/wdata    byte address / right-justified store data (sampled with cmd)
//   lsu_cmd, lsu_rnw  access size (IDLE/BYTE/HWORD/WORD), 1 = load
//   lsu_rdata         right-justified, zero-extended load data (held)
//   lsu_busy          core stall
//   lsu_err_align     one-cycle misalignment pulse
//   lsu_err_bus       one-cycle slave error / timeout pulse
//   bus_req..bus_wdata registered bus master request
//   bus_ack, bus_rdata, bus_err  slave response (rdata/err qualified by ack)

// One byte lane: enable and store byte for this lane, given the access size
// and the byte offset inside the word.
module lsu_bus_lane #(
  parameter int LANE = 0
) (
  input  logic       is_byte,
  input  logic       is_hword,
  input  logic [1:0] a,
  input  logic [7:0] b_src,   // wdata[7:0]
  input  logic [7:0] h_src,   // wdata byte of the halfword landing here
  input  logic [7:0] w_src,   // wdata byte at this lane position
  output logic       ben,
  output logic [7:0] wbyte
);
  always_comb begin
    ben   = 1'b1;
    wbyte = w_src;
    if (is_byte) begin
      ben   = (a == 2'(LANE));
      wbyte = b_src;
    end else if (is_hword) begin
      // aligned halfwords sit at offset 0 or 2, so only a[1] picks the half
      ben   = (a[1] == 1'(LANE / 2));
      wbyte = h_src;
    end
  end
endmodule

module lsu_bus_ctrl #(
  parameter int CPU_ADDR_WIDTH  = 32,
  parameter int CPU_DATA_WIDTH  = 32,
  parameter int CPU_LSUOP_WIDTH = 2,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [CPU_ADDR_WIDTH-1:0]  lsu_addr,
  input  logic [CPU_DATA_WIDTH-1:0]  lsu_wdata,
  input  logic [CPU_LSUOP_WIDTH-1:0] lsu_cmd,
  input  logic                       lsu_rnw,
  output logic [CPU_DATA_WIDTH-1:0]  lsu_rdata,
  output logic                       lsu_busy,
  output logic                       lsu_err_align,
  output logic                       lsu_err_bus,
  output logic                       bus_req,
  output logic [CPU_ADDR_WIDTH-1:0]  bus_addr,
  output logic                       bus_rnw,
  output logic [3:0]                 bus_ben,
  output logic [CPU_DATA_WIDTH-1:0]  bus_wdata,
  input  logic                       bus_ack,
  input  logic [CPU_DATA_WIDTH-1:0]  bus_rdata,
  input  logic                       bus_err
);
  localparam int NUM_LANES = 4;
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CPU_LSUOP_WIDTH-1:0] CMD_IDLE  = CPU_LSUOP_WIDTH'(0);
  localparam logic [CPU_LSUOP_WIDTH-1:0] CMD_BYTE  = CPU_LSUOP_WIDTH'(1);
  localparam logic [CPU_LSUOP_WIDTH-1:0] CMD_HWORD = CPU_LSUOP_WIDTH'(2);
  localparam logic [CPU_LSUOP_WIDTH-1:0] CMD_WORD  = CPU_LSUOP_WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                       state, state_nxt;
  logic [CNT_W-1:0]             tmo_cnt;
  logic [1:0]                   a_q;
  logic [CPU_LSUOP_WIDTH-1:0]   size_q;
  logic                         accept, misalign, expire;
  logic [NUM_LANES-1:0]         lane_ben;
  logic [NUM_LANES-1:0][7:0]    lane_wdata;
  logic [CPU_DATA_WIDTH-1:0]    rd_shift, rd_steer;

  assign accept   = (state != S_REQ) && (lsu_cmd != CMD_IDLE);
  assign misalign = ((lsu_cmd == CMD_HWORD) && lsu_addr[0]) ||
                    ((lsu_cmd == CMD_WORD)  && (lsu_addr[1:0] != 2'b00));
  // last waiting cycle: bus_req has then been high TIMEOUT_CYCLES cycles
  assign expire   = (TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // lane steering, computed from the live request and captured on accept
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lsu_bus_lane #(.LANE(i)) u_lane (
      .is_byte  (lsu_cmd == CMD_BYTE),
      .is_hword (lsu_cmd == CMD_HWORD),
      .a        (lsu_addr[1:0]),
      .b_src    (lsu_wdata[7:0]),
      .h_src    (lsu_wdata[8*(i%2) +: 8]),
      .w_src    (lsu_wdata[8*i +: 8]),
      .ben      (lane_ben[i]),
      .wbyte    (lane_wdata[i])
    );
  end

  // load data: shift the addressed bytes down, zero the rest
  assign rd_shift = bus_rdata >> {a_q, 3'b000};
  always_comb begin
    rd_steer = rd_shift;
    if (size_q == CMD_BYTE)
      rd_steer = {{(CPU_DATA_WIDTH-8){1'b0}}, rd_shift[7:0]};
    else if (size_q == CMD_HWORD)
      rd_steer = {{(CPU_DATA_WIDTH-16){1'b0}}, rd_shift[15:0]};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lsu_busy  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          lsu_busy  = 1'b1;
          state_nxt = misalign ? S_DONE : S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_REQ: begin
        lsu_busy = 1'b1;
        if (bus_ack || expire) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bus_req       <= 1'b0;
      bus_addr      <= '0;
      bus_rnw       <= 1'b0;
      bus_ben       <= '0;
      bus_wdata     <= '0;
      lsu_rdata     <= '0;
      lsu_err_align <= 1'b0;
      lsu_err_bus   <= 1'b0;
      tmo_cnt       <= '0;
      a_q           <= '0;
      size_q        <= CMD_IDLE;
    end else begin
      // error flags live only for the DONE cycle
      lsu_err_align <= 1'b0;
      lsu_err_bus   <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_q       <= lsu_addr[1:0];
            size_q    <= lsu_cmd;
            bus_rnw   <= lsu_rnw;
            bus_addr  <= {lsu_addr[CPU_ADDR_WIDTH-1:2], 2'b00};
            bus_wdata <= lane_wdata;
            tmo_cnt   <= '0;
            if (misalign) begin
              lsu_err_align <= 1'b1;
            end else begin
              bus_req <= 1'b1;
              bus_ben <= lane_ben;
            end
          end
        end
        S_REQ: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // ack wins over an expiry in the same cycle
          if (bus_ack) begin
            bus_req <= 1'b0;
            bus_ben <= '0;
            if (bus_err)      lsu_err_bus <= 1'b1;
            else if (bus_rnw) lsu_rdata   <= rd_steer;
          end else if (expire) begin
            bus_req     <= 1'b0;
            bus_ben     <= '0;
            lsu_err_bus <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_bus_ctrl.sv
module tb_lsu_bus_ctrl;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [1:0]  lsu_cmd = 2'd0;
  logic        lsu_rnw = 1'b0, lsu_busy, lsu_err_align, lsu_err_bus;
  logic        bus_req, bus_rnw, bus_ack = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0]  bus_ben;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .nrst(nrst),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_cmd(lsu_cmd), .lsu_rnw(lsu_rnw),
    .lsu_rdata(lsu_rdata), .lsu_busy(lsu_busy),
    .lsu_err_align(lsu_err_align), .lsu_err_bus(lsu_err_bus),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_rnw(bus_rnw), .bus_ben(bus_ben),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          t0;        // cycle the command was presented
    logic        align;
    logic        berr;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        rnw;
    int          req_len;   // cycles bus_req is high
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    int          wait_cyc;
    logic        err;
    logic [31:0] rdata;
  } plan_t;

  exp_t        sb_q[$];
  plan_t       plan_q[$];
  int          checks = 0, errors = 0;
  int          cyc = 0;
  bit          rst_test = 1'b0;
  logic [31:0] rdata_model = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte count from the size code, enables as a run of
  // ones at the offset, replication by multiplication.
  task automatic issue(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic rnw, input int wait_cyc, input logic err,
                       input logic [31:0] rdata, input bit b2b);
    exp_t  e;
    int    nb, a;
    bit    tmo_hit;
    logic [63:0] m;
    int    n;
    nb = (cmd == 2'd1) ? 1 : (cmd == 2'd2) ? 2 : 4;
    a  = int'(addr % 4);
    e.t0 = cyc; e.rnw = rnw; e.addr = addr & ~32'd3;
    e.align = ((a % nb) != 0);
    e.berr = 1'b0; e.ben = '0; e.wdata = '0; e.req_len = 0;
    if (!e.align) begin
      e.ben   = 4'(((1 << nb) - 1) << a);
      e.wdata = (nb == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
                (nb == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
      tmo_hit   = (TMO != 0) && (wait_cyc >= TMO);
      e.req_len = tmo_hit ? TMO : wait_cyc + 1;
      e.berr    = tmo_hit || err;
      if (!e.berr && rnw) begin
        m = (64'd1 << (8 * nb)) - 64'd1;
        rdata_model = 32'((64'(rdata) >> (8 * a)) & m);
      end
      plan_q.push_back('{wait_cyc, err, rdata});
    end
    e.rdata = rdata_model;
    if (!rst_test) sb_q.push_back(e);
    lsu_cmd = cmd; lsu_addr = addr; lsu_wdata = wdata; lsu_rnw = rnw;
    @(posedge clk); #1;
    lsu_cmd = 2'd0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_rnw = 1'($urandom);
    if (rst_test) return;
    n = 0;
    while (lsu_busy && n < 40) begin @(posedge clk); #1; n++; end
    if (lsu_busy) begin
      errors++;
      $display("FAIL busy_bound: got busy after %0d cycles expected release", n);
    end
    if (!b2b) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
  endtask

  // Bus slave: follows the plan queued for each accepted request.
  initial begin : slave
    plan_t p;
    int    cnt = 0;
    bit    active = 0, acking = 0;
    p = '{0, 1'b0, 32'h0};
    forever begin
      @(posedge clk); #1;
      bus_rdata = $urandom;
      if (acking) begin
        bus_ack = 1'b0; bus_err = 1'b0; acking = 0; active = 0;
      end else if (nrst && bus_req) begin
        if (!active) begin
          active = 1; cnt = 0;
          if (plan_q.size() == 0) begin
            errors++;
            $display("FAIL slave_plan: got bus_req expected no request");
            p = '{1000, 1'b0, 32'h0};
          end else p = plan_q.pop_front();
        end else cnt++;
        if (cnt == p.wait_cyc) begin
          bus_ack = 1'b1; bus_err = p.err; bus_rdata = p.rdata; acking = 1;
        end
      end else active = 0;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard head.
  initial begin : monitor
    exp_t e;
    bit   in_req = 0, done_now;
    int   req_cnt = 0;
    e = '{0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 0, 32'h0};
    forever begin
      @(negedge clk);
      if (!nrst || rst_test) begin
        in_req = 0;
      end else begin
        done_now = 0;
        if (bus_req) begin
          if (!in_req) begin
            in_req = 1; req_cnt = 0;
            if (sb_q.size() == 0) begin
              errors++;
              $display("FAIL sb_empty: got bus_req expected none");
            end else begin
              e = sb_q[0];
              chk("req_start_cycle", 32'(cyc), 32'(e.t0 + 1));
            end
          end
          req_cnt++;
          chk("bus_addr", bus_addr, e.addr);
          chk("bus_ben", 32'(bus_ben), 32'(e.ben));
          chk("bus_wdata", bus_wdata, e.wdata);
          chk("bus_rnw", 32'(bus_rnw), 32'(e.rnw));
          chk("busy_in_req", 32'(lsu_busy), 32'd1);
        end else begin
          chk("ben_idle", 32'(bus_ben), 32'd0);
          if (in_req || lsu_err_align) done_now = 1;
        end
        if (!done_now) begin
          chk("no_err_pulse", {30'd0, lsu_err_bus, lsu_err_align}, 32'd0);
        end else begin
          in_req = 0;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty_done: got completion expected none");
          end else begin
            e = sb_q.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.t0 + e.req_len + 1));
            chk("req_len", 32'(req_cnt), 32'(e.req_len));
            chk("err_align", 32'(lsu_err_align), 32'(e.align));
            chk("err_bus", 32'(lsu_err_bus), 32'(e.berr));
            chk("lsu_rdata", lsu_rdata, e.rdata);
            chk("busy_done", 32'(lsu_busy), 32'(lsu_cmd != 2'd0));
          end
          req_cnt = 0;
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bus_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_bus_ben"}, 32'(bus_ben), 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_bus_rnw"}, 32'(bus_rnw), 32'd0);
    chk({tag, "_lsu_rdata"}, lsu_rdata, 32'd0);
    chk({tag, "_errs"}, {30'd0, lsu_err_bus, lsu_err_align}, 32'd0);
    chk({tag, "_busy"}, 32'(lsu_busy), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    #12 chk_reset_vals("reset");
    @(posedge clk); #1 nrst = 1'b1;
    @(posedge clk); #1;

    // directed cases
    issue(2'd3, 32'h100, 32'h0, 1'b1, 0, 1'b0, 32'hDEADBEEF, 0);
    issue(2'd1, 32'h103, 32'h0, 1'b1, 0, 1'b0, 32'hA1B2C3D4, 0);
    issue(2'd2, 32'h202, 32'h1234, 1'b0, 3, 1'b0, 32'h0, 0);
    issue(2'd3, 32'h101, 32'h0, 1'b1, 0, 1'b0, 32'h0, 0);
    issue(2'd3, 32'h104, 32'h0, 1'b1, 1, 1'b1, 32'h55555555, 0);
    issue(2'd2, 32'h106, 32'h0, 1'b1, 1000, 1'b0, 32'h0, 0);
    issue(2'd3, 32'h108, 32'h0, 1'b1, TMO - 1, 1'b0, 32'h87654321, 1);
    issue(2'd2, 32'h10B, 32'h0, 1'b1, 0, 1'b0, 32'h0, 1);
    issue(2'd1, 32'h10E, 32'h0, 1'b1, 2, 1'b0, 32'h11223344, 0);

    // random traffic, including back-to-back from DONE
    for (int i = 0; i < 300; i++)
      issue(2'($urandom_range(1, 3)), $urandom, $urandom, 1'($urandom),
            $urandom_range(0, TMO + 1), ($urandom_range(0, 7) == 0), $urandom,
            bit'($urandom_range(0, 1)));

    // make rdata nonzero, then reset in the middle of a request
    issue(2'd3, 32'h400, 32'h0, 1'b1, 0, 1'b0, 32'hCAFEF00D, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_test = 1'b1;
    issue(2'd3, 32'h300, 32'hFFFFFFFF, 1'b1, 1000, 1'b0, 32'h0, 0);
    chk("rst_pre_req", 32'(bus_req), 32'd1);
    @(posedge clk); #3 nrst = 1'b0;
    #1 chk_reset_vals("midreq_reset");
    rdata_model = '0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    plan_q.delete(); sb_q.delete();
    rst_test = 1'b0;
    @(posedge clk); #1;
    issue(2'd2, 32'h502, 32'h0, 1'b1, 1, 1'b0, 32'hBEEF0000, 0);

    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
